fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  LEGv8 instruction fetch stage and IF/ID pipeline register, directly upstream of maindec.
//  Holds PC, issues word fetches to instruction memory over a req/ack handshake, and buffers
//  one returned word. Presents id_instr/id_pc/id_valid to decode; id_op = id_instr[31:21]
//  drives maindec.Op. Accepts taken-branch redirects (PCSrc/PCBranch) and decode stalls.
// PARAMETERS
//  N        64             PC / address width in bits
//  RESET_PC {N{1'b0}}      PC value loaded at reset
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  imem_req      out  1   fetch request valid
//  imem_addr     out  N   fetch byte address (word aligned)
//  imem_ack      in   1   memory returns imem_rdata this cycle
//  imem_rdata    in   32  fetched instruction word
//  id_stall      in   1   decode cannot accept; hold IF/ID contents
//  PCSrc         in   1   taken branch; redirect fetch to PCBranch
//  PCBranch      in   N   branch target byte address
//  id_valid      out  1   IF/ID holds a live instruction
//  id_instr      out  32  IF/ID instruction
//  id_pc         out  N   address of id_instr
//  id_op         out  11  id_instr[31:21], opcode to maindec
// BEHAVIOUR
//  Reset: pc=RESET_PC; id_valid=0, id_instr=0, id_pc=0, imem_req=0; skid empty; state IDLE.
//  FSM (registered):
//   IDLE  -> FETCH next cycle (first request one cycle after reset deassertion).
//   FETCH imem_req=1, imem_addr=pc; req/addr stay stable until imem_ack (never retracted).
//         On ack: IF/ID free (!id_valid | !id_stall) -> load id_*, id_valid=1, pc+=4, stay FETCH.
//         IF/ID busy -> word into skid buffer, pc+=4, -> FULL.
//   FULL  imem_req=0. When !id_stall: skid moves to IF/ID, skid empties, -> FETCH.
//   DROP  imem_req=1 at old address until ack; returned word discarded; -> FETCH.
//  IF/ID free, no ack this cycle: id_valid drops to 0 (bubble); id_instr/id_pc keep last value.
//  Redirect (PCSrc=1), priority over stall and ack:
//   pc <= {PCBranch[N-1:2],2'b00}; id_valid=0; skid cleared.
//   Outstanding FETCH without ack this cycle -> DROP; otherwise -> FETCH (same-cycle ack discarded).
//  Max one outstanding request; skid depth 1; no instruction lost or duplicated under any stall pattern.
//  PC arithmetic modulo 2^N (wraps at top). Latency: ack cycle -> id_valid next edge.
//  Reset asserted mid-transaction: all state cleared immediately; pending ack ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra output fetch_count [31:0], reset 0, +1 on every cycle an
//   instruction enters IF/ID (direct or from skid), wraps at 2^32, not cleared by redirect.
//  Undefined: port and counter absent; other behaviour identical.
// STRUCTURE
//  Package fetch_pkg: fetch_state_t enum {IDLE,FETCH,FULL,DROP}; INSTR_W=32; OP_MSB=31;
//   OP_LSB=21; PC_INCR=4.
//  Sub-module fetch_skid_buf: 1-entry {instr,pc} buffer with load/drain/clear, valid flag.
// TESTING
//  1 Reset, RESET_PC=0, ack same cycle as each req -> imem_addr 0,4,8; id_pc 0,4,8 back-to-back.
//  2 id_stall=1 two cycles while ack at addr 8 -> word in skid, imem_req=0; unstall -> id_pc 8, then 12.
//  3 PCSrc=1, PCBranch=0x103, req at 0x10 pending -> DROP, 0x10 data discarded, next req 0x100.
//  4 PCSrc=1 and id_stall=1 same cycle -> id_valid=0, skid empty, next fetch at target.
//  5 pc=2^N-4, ack -> next imem_addr=0; reset mid-wait -> outputs zero asynchronously.
//  6 Feed 11'b111_1100_0010 (LDUR) in imem_rdata[31:21] -> id_op matches; count via FETCH_PERF_EN.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the LEGv8 instruction fetch stage.
//   fetch_state_t : fetch controller states (IDLE, FETCH, FULL, DROP)
//   INSTR_W       : instruction word width
//   OP_MSB/OP_LSB : opcode field of the instruction word handed to maindec
//   PC_INCR       : byte distance between sequential instructions
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 21;
  localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for an {instruction, pc} pair. It catches a word
// returned by instruction memory while the IF/ID register is stalled.
// Ports:
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   load            : capture in_instr/in_pc, mark entry valid
//   drain           : entry consumed by IF/ID, mark empty
//   clear           : discard entry (redirect), has priority over load/drain
//   in_instr, in_pc : data to capture
//   valid           : entry holds a word
//   instr, pc       : stored data
// ---------------------------------------------------------------------------
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [N-1:0]       in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [N-1:0]       pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// LEGv8 instruction fetch stage plus IF/ID pipeline register. Holds the PC,
// fetches one word at a time from instruction memory over a req/ack
// handshake, buffers one returned word while decode is stalled, and follows
// taken-branch redirects.
// Optional feature macro: FETCH_PERF_EN adds output fetch_count, a 32-bit
// count of instructions entering IF/ID.
// Parameters:
//   N        : PC / address width
//   RESET_PC : PC loaded at reset
// Ports:
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   imem_req, imem_addr   : fetch request and word-aligned byte address
//   imem_ack, imem_rdata  : memory response and returned instruction
//   id_stall              : decode cannot accept a new instruction
//   PCSrc, PCBranch       : taken branch and its target byte address
//   id_valid, id_instr,
//   id_pc, id_op          : IF/ID contents; id_op is the maindec opcode field
//   fetch_count           : (FETCH_PERF_EN only) instructions delivered
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [N-1:0]             imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     id_stall,
  input  logic                     PCSrc,
  input  logic [N-1:0]             PCBranch,
  output logic                     id_valid,
  output logic [INSTR_W-1:0]       id_instr,
  output logic [N-1:0]             id_pc,
  output logic [OP_MSB-OP_LSB:0]   id_op
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              fetch_count
`endif
);

  localparam logic [N-1:0] ALIGN_MASK = ~N'(3);
  localparam logic [N-1:0] INCR       = N'(PC_INCR);

  fetch_state_t       state_q, state_d;
  logic [N-1:0]       pc_q, pc_d;
  logic [N-1:0]       drop_addr_q, drop_addr_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [N-1:0]       id_pc_q, id_pc_d;

  logic               skid_load, skid_drain, skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [N-1:0]       skid_pc;
  logic               id_enter;
  logic               if_id_free;

  fetch_skid_buf #(.N(N)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (skid_clear),
    .in_instr (imem_rdata),
    .in_pc    (pc_q),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // IF/ID can take a new word when it is empty or decode consumes it now.
  assign if_id_free = !id_valid_q || !id_stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;
    id_enter    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        id_valid_d = 1'b0;
      end
      FETCH: begin
        if (imem_ack) begin
          pc_d = pc_q + INCR;
          if (if_id_free) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_enter   = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = FULL;
          end
        end else if (if_id_free) begin
          id_valid_d = 1'b0;
        end
      end
      FULL: begin
        if (!id_stall) begin
          id_valid_d = 1'b1;
          id_instr_d = skid_instr;
          id_pc_d    = skid_pc;
          id_enter   = 1'b1;
          skid_drain = 1'b1;
          state_d    = FETCH;
        end
      end
      DROP: begin
        // The word returned here belongs to the abandoned path.
        if (if_id_free) begin
          id_valid_d = 1'b0;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A taken branch overrides everything: flush IF/ID and the skid, and if
    // a request is still in flight keep it alive in DROP so the handshake is
    // never retracted.
    if (PCSrc) begin
      pc_d       = PCBranch & ALIGN_MASK;
      id_valid_d = 1'b0;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_enter   = 1'b0;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b1;
      if ((state_q == FETCH || state_q == DROP) && !imem_ack) begin
        state_d = DROP;
        if (state_q == FETCH) begin
          drop_addr_d = pc_q;
        end
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q + {31'd0, id_enter};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`endif

  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_op     = id_instr_q[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed-vector bench for fetch_stage (N=64, RESET_PC=0). Each vector sets
// the inputs, advances one clock and compares outputs against hand-computed
// values. Define FETCH_PERF_EN to also check fetch_count.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        PCSrc;
  logic [63:0] PCBranch;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [10:0] id_op;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  int vecCount;
  int missCount;

  localparam logic [31:0] I0   = 32'h8B020020;
  localparam logic [31:0] I1   = 32'hCB030041;
  localparam logic [31:0] I2   = 32'h91000462;
  localparam logic [31:0] I3   = 32'hF8401234;
  localparam logic [31:0] I4   = 32'hB4000083;
  localparam logic [31:0] I5   = 32'h17FFFFFE;
  localparam logic [31:0] I6   = 32'hAA0400A5;
  localparam logic [31:0] I7   = 32'hD2800106;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .PCSrc      (PCSrc),
    .PCBranch   (PCBranch),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_op      (id_op)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance past the next rising edge, settle.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic stall, input logic pcsrc,
                               input logic [63:0] target);
    imem_ack   = ack;
    imem_rdata = rdata;
    id_stall   = stall;
    PCSrc      = pcsrc;
    PCBranch   = target;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecCount   = 0;
    missCount  = 0;
    reset      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    id_stall   = 1'b0;
    PCSrc      = 1'b0;
    PCBranch   = '0;

    // Reset state
    #1;
    checkOutput("rst_req",   64'(imem_req), 64'd0);
    checkOutput("rst_valid", 64'(id_valid), 64'd0);
    checkOutput("rst_instr", 64'(id_instr), 64'd0);
    checkOutput("rst_pc",    id_pc,         64'd0);
    checkOutput("rst_addr",  imem_addr,     64'd0);
`ifdef FETCH_PERF_EN
    checkOutput("rst_count", 64'(fetch_count), 64'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // IDLE -> FETCH: first request one cycle after reset release
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("first_req",  64'(imem_req), 64'd1);
    checkOutput("first_addr", imem_addr,     64'd0);
    checkOutput("first_vld",  64'(id_valid), 64'd0);

    // Back-to-back fetches with same-cycle ack
    applyStimulus(1'b1, I0, 1'b0, 1'b0, '0);
    checkOutput("b2b0_pc",    id_pc,          64'h0);
    checkOutput("b2b0_instr", 64'(id_instr),  64'(I0));
    checkOutput("b2b0_vld",   64'(id_valid),  64'd1);
    checkOutput("b2b0_addr",  imem_addr,      64'h4);
    applyStimulus(1'b1, I1, 1'b0, 1'b0, '0);
    checkOutput("b2b1_pc",    id_pc,          64'h4);
    checkOutput("b2b1_addr",  imem_addr,      64'h8);

    // Stall while word at 0x8 returns: goes to skid, request drops
    applyStimulus(1'b1, I2, 1'b1, 1'b0, '0);
    checkOutput("stall1_req",   64'(imem_req), 64'd0);
    checkOutput("stall1_pc",    id_pc,         64'h4);
    checkOutput("stall1_instr", 64'(id_instr), 64'(I1));
    checkOutput("stall1_vld",   64'(id_valid), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("stall2_req",   64'(imem_req), 64'd0);
    checkOutput("stall2_pc",    id_pc,         64'h4);

    // Unstall: skid word moves into IF/ID, fetching resumes at 0xC
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("drain_pc",    id_pc,         64'h8);
    checkOutput("drain_instr", 64'(id_instr), 64'(I2));
    checkOutput("drain_req",   64'(imem_req), 64'd1);
    checkOutput("drain_addr",  imem_addr,     64'hC);

    // LDUR opcode delivered at 0xC
    applyStimulus(1'b1, I3, 1'b0, 1'b0, '0);
    checkOutput("ldur_pc",  id_pc,       64'hC);
    checkOutput("ldur_op",  64'(id_op),  64'(11'b111_1100_0010));
    checkOutput("ldur_addr", imem_addr,  64'h10);

    // No ack: bubble, id_pc keeps last value, request at 0x10 pending
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("bubble_vld", 64'(id_valid), 64'd0);
    checkOutput("bubble_pc",  id_pc,         64'hC);
    checkOutput("bubble_req", 64'(imem_req), 64'd1);

    // Redirect to 0x103 while 0x10 is outstanding -> DROP at old address
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h103);
    checkOutput("drop_req",  64'(imem_req), 64'd1);
    checkOutput("drop_addr", imem_addr,     64'h10);
    checkOutput("drop_vld",  64'(id_valid), 64'd0);
    applyStimulus(1'b1, JUNK, 1'b0, 1'b0, '0);
    checkOutput("dropack_vld",   64'(id_valid), 64'd0);
    checkOutput("dropack_instr", 64'(id_instr), 64'(I3));
    checkOutput("dropack_addr",  imem_addr,     64'h100);
    applyStimulus(1'b1, I4, 1'b0, 1'b0, '0);
    checkOutput("target_pc",    id_pc,         64'h100);
    checkOutput("target_instr", 64'(id_instr), 64'(I4));

    // Redirect during stall with a word sitting in skid
    applyStimulus(1'b1, I5, 1'b1, 1'b0, '0);
    checkOutput("skid2_req", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h200);
    checkOutput("rdst_vld",  64'(id_valid), 64'd0);
    checkOutput("rdst_req",  64'(imem_req), 64'd1);
    checkOutput("rdst_addr", imem_addr,     64'h200);
    applyStimulus(1'b1, I6, 1'b0, 1'b0, '0);
    checkOutput("rdst_pc",    id_pc,         64'h200);
    checkOutput("rdst_instr", 64'(id_instr), 64'(I6));

    // Redirect with same-cycle ack: word discarded, fetch top-of-space, wrap
    applyStimulus(1'b1, JUNK, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("rack_vld",  64'(id_valid), 64'd0);
    checkOutput("rack_addr", imem_addr,     64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, I7, 1'b0, 1'b0, '0);
    checkOutput("wrap_pc",   id_pc,         64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_addr", imem_addr,     64'h0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_count", 64'(fetch_count), 64'd7);
`endif

    // Reset mid-wait: outputs clear without a clock edge, ack ignored
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("pend_req", 64'(imem_req), 64'd1);
    #2;
    imem_ack   = 1'b1;
    imem_rdata = JUNK;
    reset      = 1'b0;
    #1;
    checkOutput("arst_req",   64'(imem_req), 64'd0);
    checkOutput("arst_vld",   64'(id_valid), 64'd0);
    checkOutput("arst_instr", 64'(id_instr), 64'd0);
    checkOutput("arst_pc",    id_pc,         64'd0);
`ifdef FETCH_PERF_EN
    checkOutput("arst_count", 64'(fetch_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    checkOutput("arst_hold_vld", 64'(id_valid), 64'd0);
    checkOutput("arst_hold_req", 64'(imem_req), 64'd0);
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("rerun_req",  64'(imem_req), 64'd1);
    checkOutput("rerun_addr", imem_addr,     64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
